// File: rtl/mc_control.sv
// mc_control: multicycle control unit for the RV32I core.
//
// A Moore state machine that sequences the shared ALU, register file,
// unified instruction/data memory and PC register over several cycles per
// instruction. The branch decision is folded into pc_write, the unit counts
// retired instructions and parks in TRAP on an unsupported opcode.
//
// Optional feature: define MC_BRANCH_ALL_EN to resolve beq/bne/blt/bge in
// BRANCH. Without it only beq can be taken and lt is ignored.
//
// Ports:
//   clk, rst_n          core clock (rising edge), async active-low reset
//   opcode, funct3      instruction fields from the instruction register
//   zero, lt            ALU flags (lt used only with MC_BRANCH_ALL_EN)
//   mem_ready           memory completes the current access this cycle
//   pc_write, ir_write  PC / instruction-register load enables
//   mem_read, mem_write memory strobes
//   reg_write           register-file write enable
//   adr_src             memory address select (0 = PC, 1 = ALU-out register)
//   alu_src_a/b, alu_op ALU operand selects and operation
//   result_src          result select
//   state               current state, for debug
//   illegal             high while trapped
//   retired             16-bit wrapping retired-instruction count
module mc_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        lt,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t cur;
  state_t nxt;
  logic   taken;
  logic   retire;
  logic   pc_write_raw;
  logic   ir_write_raw;
  logic   mem_read_raw;
  logic   mem_write_raw;
  logic   reg_write_raw;
  logic   illegal_raw;

  assign state = cur;

`ifdef MC_BRANCH_ALL_EN
  // Branch condition for the full beq/bne/blt/bge set.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      default: taken = 1'b0;
    endcase
  end
`else
  // Only beq is supported; lt is deliberately left unconnected.
  logic unused_lt;
  assign unused_lt = lt;
  assign taken     = zero & (funct3 == 3'b000);
`endif

  // Next-state decode.
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: nxt = S_MEMADR;
          7'b0110011:             nxt = S_EXECR;
          7'b0010011:             nxt = S_EXECI;
          7'b1101111:             nxt = S_JAL;
          7'b1100011:             nxt = S_BRANCH;
          default:                nxt = S_TRAP;
        endcase
      end
      // opcode is still the lw/sw seen in DECODE; bit 5 separates them.
      S_MEMADR:   nxt = (opcode == 7'b0100011) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_BRANCH:   nxt = S_FETCH;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_TRAP;
    endcase
  end

  // An instruction retires when one of its final states hands back to FETCH.
  assign retire = (nxt == S_FETCH) &&
                  ((cur == S_MEMWB) || (cur == S_MEMWRITE) ||
                   (cur == S_ALUWB) || (cur == S_BRANCH));

  // State register and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_FETCH;
      retired <= 16'd0;
    end else begin
      cur <= nxt;
      if (retire) begin
        retired <= retired + 16'd1;
      end else begin
        retired <= retired;
      end
    end
  end

  // Moore output decode; FETCH and BRANCH also look at mem_ready / taken.
  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    case (cur)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src      = 1'b1;
        mem_read_raw = 1'b1;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_JAL: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b01;
        pc_write_raw = taken;
      end
      S_TRAP: begin
        illegal_raw = 1'b1;
      end
      default: begin
        illegal_raw = 1'b1;
      end
    endcase
  end

  // The reset state is FETCH, so the strobes are gated to stay quiet while
  // rst_n is held low.
  assign pc_write  = pc_write_raw  & rst_n;
  assign ir_write  = ir_write_raw  & rst_n;
  assign mem_read  = mem_read_raw  & rst_n;
  assign mem_write = mem_write_raw & rst_n;
  assign reg_write = reg_write_raw & rst_n;
  assign illegal   = illegal_raw   & rst_n;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        lt;
  logic        mem_ready;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        adr_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  result_src;
  logic [3:0]  state;
  logic        illegal;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;
  int model_ret = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .zero(zero), .lt(lt), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .state(state), .illegal(illegal),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Branch outcome straight from the ISA definition of each funct3.
  function automatic bit ref_taken(input logic [2:0] f3, input bit z, input bit l);
`ifdef MC_BRANCH_ALL_EN
    return (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) ||
           (f3 == 3'd4 && l) || (f3 == 3'd5 && !l);
`else
    return (f3 == 3'd0) && z;
`endif
  endfunction

  // Expected {alu_src_a, alu_src_b, alu_op, result_src} from the state table.
  function automatic logic [7:0] ref_mux(input int s);
    case (s)
      0:  return 8'b00_10_00_10;
      1:  return 8'b01_01_00_00;
      2:  return 8'b10_01_00_00;
      4:  return 8'b00_00_00_01;
      6:  return 8'b10_00_10_00;
      8:  return 8'b10_01_10_00;
      9:  return 8'b01_10_00_00;
      10: return 8'b10_00_01_00;
      default: return 8'b00_00_00_00;
    endcase
  endfunction

  // Runs one instruction: builds the state walk the instruction should take
  // (with sf fetch stalls and sm data stalls) and checks every cycle of it.
  task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3,
                            input int sf, input int sm, input bit rnd,
                            input bit zv, input bit lv);
    int  path[$];
    bit  is_trap;
    path = {};
    is_trap = 1'b0;
    repeat (sf + 1) path.push_back(0);
    path.push_back(1);
    case (op)
      OP_LW:  begin path.push_back(2); repeat (sm + 1) path.push_back(3); path.push_back(4); end
      OP_SW:  begin path.push_back(2); repeat (sm + 1) path.push_back(5); end
      OP_R:   begin path.push_back(6); path.push_back(7); end
      OP_I:   begin path.push_back(8); path.push_back(7); end
      OP_JAL: begin path.push_back(9); path.push_back(7); end
      OP_BR:  path.push_back(10);
      default: begin is_trap = 1'b1; repeat (12) path.push_back(11); end
    endcase
    for (int i = 0; i < path.size(); i++) begin
      int         s;
      bit         done_wait;
      bit         tk;
      logic [6:0] exp_strb;
      logic [6:0] got_strb;
      logic [3:0] es;
      s = path[i];
      es = s[3:0];
      done_wait = (i + 1 == path.size()) || (path[i+1] != s);
      @(negedge clk);
      opcode = op;
      funct3 = f3;
      zero   = rnd ? 1'($urandom) : zv;
      lt     = rnd ? 1'($urandom) : lv;
      if (s == 0 || s == 3 || s == 5) mem_ready = done_wait;
      else mem_ready = 1'($urandom);
      #1;
      tk = ref_taken(f3, zero, lt);
      exp_strb = {(s == 0 && mem_ready) || s == 9 || (s == 10 && tk),
                  s == 0 && mem_ready,
                  s == 0 || s == 3,
                  s == 5,
                  s == 4 || s == 7,
                  s == 3 || s == 5,
                  s == 11};
      got_strb = {pc_write, ir_write, mem_read, mem_write, reg_write, adr_src, illegal};
      total++;
      if (state !== es) begin
        bad++;
        $display("FAIL state op=%b step=%0d got=%0d exp=%0d", op, i, state, es);
      end
      total++;
      if (got_strb !== exp_strb) begin
        bad++;
        $display("FAIL strobes op=%b f3=%b step=%0d got=%b exp=%b", op, f3, i, got_strb, exp_strb);
      end
      total++;
      if ({alu_src_a, alu_src_b, alu_op, result_src} !== ref_mux(s)) begin
        bad++;
        $display("FAIL muxsel op=%b step=%0d got=%b exp=%b", op, i,
                 {alu_src_a, alu_src_b, alu_op, result_src}, ref_mux(s));
      end
    end
    if (!is_trap) begin
      model_ret = (model_ret + 1) % 65536;
      @(posedge clk);
      #1;
      total++;
      if (state !== 4'd0 || retired !== 16'(model_ret)) begin
        bad++;
        $display("FAIL retire op=%b got_state=%0d got_ret=%0d exp_ret=%0d", op, state, retired, model_ret);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R; funct3 = 3'd0; zero = 1'b0; lt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (state !== 4'd0 || retired !== 16'd0) begin
      bad++; $display("FAIL reset_state got=%0d/%0d exp=0/0", state, retired);
    end
    total++;
    if ({pc_write, ir_write, mem_read, mem_write, reg_write, illegal} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=000000",
                      {pc_write, ir_write, mem_read, mem_write, reg_write, illegal});
    end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (mem_read !== 1'b1) begin
      bad++; $display("FAIL first_fetch mem_read got=%b exp=1", mem_read);
    end
    model_ret = 0;
  endtask

  task automatic test_rtype();
    exec_instr(OP_R, 3'd0, 0, 0, 1'b1, 1'b0, 1'b0);
    total++;
    if (retired !== 16'd1) begin
      bad++; $display("FAIL rtype_retired got=%0d exp=1", retired);
    end
  endtask

  task automatic test_lw_stall();
    exec_instr(OP_LW, 3'd2, 0, 2, 1'b1, 1'b0, 1'b0);
    exec_instr(OP_SW, 3'd2, 1, 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    exec_instr(OP_BR, 3'd0, 0, 0, 1'b0, 1'b1, 1'b0);
    exec_instr(OP_BR, 3'd0, 0, 0, 1'b0, 1'b0, 1'b1);
    exec_instr(OP_BR, 3'd1, 0, 0, 1'b0, 1'b0, 1'b0);
    exec_instr(OP_BR, 3'd4, 0, 0, 1'b0, 1'b1, 1'b1);
    exec_instr(OP_BR, 3'd5, 0, 0, 1'b0, 1'b0, 1'b0);
    exec_instr(OP_BR, 3'd2, 0, 0, 1'b0, 1'b1, 1'b1);
    exec_instr(OP_JAL, 3'd0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
    ops[3] = OP_I;  ops[4] = OP_JAL; ops[5] = OP_BR;
    for (int n = 0; n < 60; n++) begin
      exec_instr(ops[$urandom_range(5, 0)], 3'($urandom), int'($urandom_range(3, 0)),
                 int'($urandom_range(3, 0)), 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.retired = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.retired;
    #1;
    total++;
    if (retired !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_preload got=%h exp=ffff", retired);
    end
    model_ret = 65535;
    exec_instr(OP_SW, 3'd2, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midwrite();
    @(negedge clk); opcode = OP_SW; funct3 = 3'd2; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0;
    #1;
    total++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      bad++; $display("FAIL midwrite_setup got_state=%0d mem_write=%b exp=5/1", state, mem_write);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_write !== 1'b0 || state !== 4'd0 || mem_read !== 1'b0 || retired !== 16'd0) begin
      bad++; $display("FAIL midwrite_reset got mw=%b st=%0d mr=%b ret=%0d exp 0/0/0/0",
                      mem_write, state, mem_read, retired);
    end
    @(negedge clk); rst_n = 1'b1;
    model_ret = 0;
    exec_instr(OP_I, 3'd0, 0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_trap();
    exec_instr(OP_BAD, 3'd0, 0, 0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || illegal !== 1'b0 || retired !== 16'd0) begin
      bad++; $display("FAIL trap_reset got st=%0d ill=%b ret=%0d exp 0/0/0", state, illegal, retired);
    end
    @(negedge clk); rst_n = 1'b1;
    model_ret = 0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_random();
    test_wrap();
    test_reset_midwrite();
    test_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
